// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for the 7-segment scan receiver: scan-side inputs plus the
// rebuilt frame and status outputs.
interface seg_scan_decoder_if #(parameter int NDIG = 5);
  logic [7:0]        SEG;
  logic              SEGCLK;
  logic [NDIG-1:0]   SEGCAT;
  logic              CLR_ERR;
  logic [4*NDIG-1:0] DIGITS;
  logic [NDIG-1:0]   DPS;
  logic              FRAME_VLD;
  logic              BAD_SEG;
  logic              BAD_CAT;
  logic              STALE;

  modport master (output SEG, SEGCLK, SEGCAT, CLR_ERR,
                  input  DIGITS, DPS, FRAME_VLD, BAD_SEG, BAD_CAT, STALE);
  modport slave  (input  SEG, SEGCLK, SEGCAT, CLR_ERR,
                  output DIGITS, DPS, FRAME_VLD, BAD_SEG, BAD_CAT, STALE);
endinterface

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan receiver: syncs the bus, decodes each strobed
// digit to BCD and publishes a full frame once every digit slot is filled.
module seg_scan_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] nib_in,
  input  logic       dp_in,
  output logic [3:0] nib,
  output logic       dp
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nib <= '0;
      dp  <= 1'b0;
    end else if (we) begin
      nib <= nib_in;
      dp  <= dp_in;
    end
endmodule

module seg_scan_decoder #(
  parameter int NDIG    = 5,
  parameter int TIMEOUT = 4096,
  parameter int TO_BITS = 12
) (
  input  logic              SYSCLK,
  input  logic              RSTN,
  seg_scan_decoder_if.slave bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  // One spare bit so the counter can actually hold TIMEOUT == 2**TO_BITS.
  localparam logic [TO_BITS:0] TMO = (TO_BITS+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} st_t;

  function automatic logic [4:0] dec7(input logic [6:0] p);
    case (p)
      7'h7E: dec7 = 5'h00;
      7'h30: dec7 = 5'h01;
      7'h6D: dec7 = 5'h02;
      7'h79: dec7 = 5'h03;
      7'h33: dec7 = 5'h04;
      7'h5B: dec7 = 5'h05;
      7'h5F: dec7 = 5'h06;
      7'h70: dec7 = 5'h07;
      7'h7F: dec7 = 5'h08;
      7'h7B: dec7 = 5'h09;
      7'h00: dec7 = 5'h0A;
      default: dec7 = 5'h1F;   // bit 4 flags an undecodable pattern
    endcase
  endfunction

  logic [7:0]      seg_s1, seg_s2;
  logic [NDIG-1:0] cat_s1, cat_s2;
  logic [2:0]      clk_pipe;

  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      cat_s1   <= '1;
      cat_s2   <= '1;
      clk_pipe <= '0;
    end else begin
      seg_s1   <= bus.SEG;
      seg_s2   <= seg_s1;
      cat_s1   <= bus.SEGCAT;
      cat_s2   <= cat_s1;
      clk_pipe <= {clk_pipe[1:0], bus.SEGCLK};
    end

  logic            rise, cat_ok, bad_pat, cap_new;
  logic [NDIG-1:0] inv;
  logic [IW-1:0]   idx;
  logic [4:0]      dcd;

  always_comb begin
    rise    = clk_pipe[1] & ~clk_pipe[2];
    inv     = ~cat_s2;
    cat_ok  = (inv != '0) && ((inv & (inv - NDIG'(1))) == '0);
    idx     = '0;
    for (int i = 0; i < NDIG; i++)
      if (!cat_s2[i]) idx = IW'(i);
    dcd     = dec7(seg_s2[7:1]);
    bad_pat = dcd[4];
    cap_new = rise & cat_ok;
  end

  st_t             st;
  logic [NDIG-1:0] mask, mask_n, mask_base;
  logic            pend, pend_dp;
  logic [IW-1:0]   pend_idx, a_idx;
  logic [3:0]      pend_nib, a_nib;
  logic            a_dp, apply;
  logic [TO_BITS:0] cnt, cnt_nxt;
  logic            stale, stale_rise;

  // A capture landing in DONE is parked in pend and replayed the next cycle.
  always_comb begin
    apply      = (cap_new && st != DONE) || pend;
    a_idx      = pend ? pend_idx : idx;
    a_nib      = pend ? pend_nib : dcd[3:0];
    a_dp       = pend ? pend_dp  : seg_s2[0];
    mask_base  = (st == IDLE || mask[a_idx]) ? '0 : mask;
    mask_n     = mask_base | (NDIG'(1) << a_idx);
    cnt_nxt    = rise ? '0 : (cnt == TMO ? cnt : cnt + 1'b1);
    stale_rise = (cnt_nxt == TMO) && !stale;
  end

  logic [NDIG-1:0][3:0] stg_nib;
  logic [NDIG-1:0]      stg_dp;

  for (genvar g = 0; g < NDIG; g++) begin : g_slot
    seg_scan_slot u_slot (
      .clk   (SYSCLK),
      .rst_n (RSTN),
      .we    (apply && a_idx == IW'(g)),
      .nib_in(a_nib),
      .dp_in (a_dp),
      .nib   (stg_nib[g]),
      .dp    (stg_dp[g])
    );
  end

  logic [NDIG-1:0][3:0] digits_q;
  logic [NDIG-1:0]      dps_q;
  logic                 frame_vld, bad_seg, bad_cat;

  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) begin
      st        <= IDLE;
      mask      <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      pend_nib  <= '0;
      pend_dp   <= 1'b0;
      cnt       <= '0;
      stale     <= 1'b0;
      digits_q  <= '0;
      dps_q     <= '0;
      frame_vld <= 1'b0;
      bad_seg   <= 1'b0;
      bad_cat   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      stale     <= (cnt_nxt == TMO);
      frame_vld <= 1'b0;
      bad_seg   <= (bad_seg & ~bus.CLR_ERR) | (cap_new & bad_pat);
      bad_cat   <= (bad_cat & ~bus.CLR_ERR) | (rise & ~cat_ok);
      pend      <= cap_new && st == DONE;
      if (cap_new) begin
        pend_idx <= idx;
        pend_nib <= dcd[3:0];
        pend_dp  <= seg_s2[0];
      end
      if (stale_rise) begin
        mask <= '0;
        st   <= IDLE;
        pend <= 1'b0;
      end else begin
        case (st)
          IDLE, COLLECT:
            if (apply) begin
              mask <= mask_n;
              st   <= (&mask_n) ? DONE : COLLECT;
            end
          DONE: begin
            digits_q  <= stg_nib;
            dps_q     <= stg_dp;
            frame_vld <= 1'b1;
            mask      <= '0;
            st        <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end

  assign bus.DIGITS    = digits_q;
  assign bus.DPS       = dps_q;
  assign bus.FRAME_VLD = frame_vld;
  assign bus.BAD_SEG   = bad_seg;
  assign bus.BAD_CAT   = bad_cat;
  assign bus.STALE     = stale;
endmodule
